// File: rtl/cog_hub_req_if.sv
// ============================================================================
// Module      : cog_hub_req_if
// Description : Pipeline request and hub bus signals for cog_hub_req.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cog_hub_req_if;
  // hub side
  logic        ena_bus;
  logic        bus_sel_n;
  logic        bus_ack_n;
  logic [31:0] bus_q;
  logic        bus_c;
  logic        bus_r;
  logic        bus_e;
  logic        bus_w;
  logic [1:0]  bus_s;
  logic [15:0] bus_a;
  logic [31:0] bus_d;
  // pipeline side
  logic        req;
  logic        req_r;
  logic        req_w;
  logic [1:0]  req_s;
  logic [15:0] req_a;
  logic [31:0] req_d;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] res_q;
  logic        res_c;

  modport slave (
    input  ena_bus, bus_sel_n, bus_ack_n, bus_q, bus_c,
    input  req, req_r, req_w, req_s, req_a, req_d,
    output bus_r, bus_e, bus_w, bus_s, bus_a, bus_d,
    output busy, done, err, res_q, res_c
  );

  modport master (
    output ena_bus, bus_sel_n, bus_ack_n, bus_q, bus_c,
    output req, req_r, req_w, req_s, req_a, req_d,
    input  bus_r, bus_e, bus_w, bus_s, bus_a, bus_d,
    input  busy, done, err, res_q, res_c
  );
endinterface

`default_nettype wire

// File: rtl/cog_hub_req.sv
// ============================================================================
// Module      : cog_hub_req
// Description : Cog-side hub access sequencer with slot wait and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cog_hub_req #(
  parameter int unsigned TMO = 16
) (
  input wire logic     clk_cog,
  input wire logic     res,
  cog_hub_req_if.slave hub
);

  localparam logic [7:0] C_TMO = 8'(TMO);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SLOT = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_FIN       = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_r;
  logic        r_w;
  logic [1:0]  r_s;
  logic [15:0] r_a;
  logic [31:0] r_d;
  logic [7:0]  r_tmo;
  logic [7:0]  w_tmo_nxt;
  logic        r_abort;
  logic        w_abort_nxt;
  logic [31:0] r_res_q;
  logic        r_res_c;
  logic        w_accept;
  logic        w_cap;
  logic        w_slot;

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_abort_nxt = r_abort;
    w_accept    = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hub.req) begin
          w_accept    = 1'b1;
          w_abort_nxt = 1'b0;
          w_state_nxt = S_WAIT_SLOT;
        end
      end
      S_WAIT_SLOT: begin
        if (hub.ena_bus && hub.bus_sel_n) begin
          w_tmo_nxt   = 8'd0;
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // An ack on the same strobe that would hit the limit still wins.
        if (hub.ena_bus) begin
          if (hub.bus_ack_n) begin
            w_cap       = 1'b1;
            w_state_nxt = S_FIN;
          end else if (r_tmo + 8'd1 == C_TMO) begin
            w_abort_nxt = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_tmo_nxt = r_tmo + 8'd1;
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      r_state <= S_IDLE;
      r_tmo   <= 8'd0;
      r_abort <= 1'b0;
      r_r     <= 1'b0;
      r_w     <= 1'b0;
      r_s     <= 2'b00;
      r_a     <= 16'h0000;
      r_d     <= 32'h0000_0000;
      r_res_q <= 32'h0000_0000;
      r_res_c <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      r_abort <= w_abort_nxt;
      if (w_accept) begin
        r_r <= hub.req_r;
        r_w <= hub.req_w;
        r_s <= hub.req_s;
        r_a <= hub.req_a;
        r_d <= hub.req_d;
      end
      if (w_cap) begin
        r_res_q <= hub.bus_q;
        r_res_c <= hub.bus_c;
      end
    end
  end

  // The hub ORs all cogs together, so drive nothing outside our own slot.
  assign w_slot    = (r_state == S_WAIT_SLOT) && hub.bus_sel_n;
  assign hub.bus_e = w_slot;
  assign hub.bus_r = w_slot & r_r;
  assign hub.bus_w = w_slot & r_w;
  assign hub.bus_s = w_slot ? r_s : 2'b00;
  assign hub.bus_a = w_slot ? r_a : 16'h0000;
  assign hub.bus_d = w_slot ? r_d : 32'h0000_0000;

  assign hub.busy  = (r_state != S_IDLE);
  assign hub.done  = (r_state == S_FIN) && !r_abort;
  assign hub.err   = (r_state == S_FIN) && r_abort;
  assign hub.res_q = r_res_q;
  assign hub.res_c = r_res_c;

endmodule

`default_nettype wire

// File: tb/tb_cog_hub_req.sv
// ============================================================================
// Module      : tb_cog_hub_req
// Description : Randomized scoreboard bench for cog_hub_req with a hub model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cog_hub_req;

  localparam int TMO = 4;
  localparam int COG = 3;

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  s;
    logic [15:0] a;
    logic [31:0] d;
  } bus_t;

  typedef struct {
    int          delay;
    logic [31:0] q;
    logic        c;
  } hub_t;

  typedef struct {
    logic        err;
    logic [31:0] q;
    logic        c;
  } exp_t;

  logic clk_cog = 1'b0;
  logic res;
  bit   run = 1'b0;

  cog_hub_req_if hub ();

  cog_hub_req #(.TMO(TMO)) u_dut (
    .clk_cog (clk_cog),
    .res     (res),
    .hub     (hub)
  );

  always #5 clk_cog = ~clk_cog;

  int total = 0;
  int bad   = 0;

  bus_t bq[$];
  hub_t hq[$];
  exp_t exq[$];

  hub_t        cur;
  bit          counting = 1'b0;
  bit          pending  = 1'b0;
  bit          issued   = 1'b0;
  int          seen     = 0;
  int          sel_idx  = 0;
  logic [31:0] mq       = 32'h0;
  logic        mc       = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the hub model: sees the bus as the hub did at the edge,
  // then presents the next cycle's strobe, slot select and ack.
  task automatic tick();
    logic snap_e;
    @(negedge clk_cog);
    snap_e = hub.bus_e;
    @(posedge clk_cog);
    #1;
    if (res) begin
      counting = 1'b0;
      pending  = 1'b0;
      issued   = 1'b0;
      hq.delete();
    end else begin
      if (hub.ena_bus) begin
        if (snap_e && hq.size() != 0) begin
          cur      = hq.pop_front();
          counting = 1'b1;
          seen     = 0;
          pending  = 1'b0;
        end else if (counting) begin
          seen++;
          if (hub.bus_ack_n || seen >= TMO) counting = 1'b0;
        end
      end
      if (issued) pending = 1'b1;
      issued = 1'b0;
    end
    if (hub.ena_bus) sel_idx = (sel_idx + 1) % 8;
    hub.ena_bus   = ($urandom_range(0, 2) != 0);
    hub.bus_sel_n = (sel_idx == COG);
    hub.bus_ack_n = counting && hub.ena_bus && (seen + 1 == cur.delay);
    hub.bus_q     = hub.bus_ack_n ? cur.q : $urandom;
    hub.bus_c     = hub.bus_ack_n ? cur.c : 1'($urandom);
    hub.req       = 1'b0;
  endtask

  // Ack arriving on strobe 1..TMO of the ack wait completes; none aborts.
  task automatic issue(input int force_d);
    bus_t b;
    hub_t h;
    exp_t e;
    int   k;
    b.r = 1'($urandom);
    b.w = 1'($urandom);
    b.s = 2'($urandom);
    b.a = 16'($urandom);
    b.d = $urandom;
    if (force_d >= 0) begin
      h.delay = force_d;
    end else begin
      k = int'($urandom_range(0, 9));
      h.delay = (k < 5) ? 2 : (k < 8) ? int'($urandom_range(1, TMO)) : 0;
    end
    h.q = $urandom;
    h.c = 1'($urandom);
    if (h.delay != 0) begin
      e.err = 1'b0; e.q = h.q; e.c = h.c;
      mq = h.q; mc = h.c;
    end else begin
      e.err = 1'b1; e.q = mq; e.c = mc;
    end
    bq.push_back(b);
    hq.push_back(h);
    exq.push_back(e);
    hub.req   = 1'b1;
    hub.req_r = b.r;
    hub.req_w = b.w;
    hub.req_s = b.s;
    hub.req_a = b.a;
    hub.req_d = b.d;
    issued    = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((hub.busy || exq.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_bound", 64'(n < 300), 64'd1);
  endtask

  // Monitor: bus ownership every cycle, completion against the scoreboard.
  initial begin
    exp_t e;
    bus_t b;
    wait (run);
    forever begin
      @(negedge clk_cog);
      chk("bus_e", 64'(hub.bus_e), 64'(pending && hub.bus_sel_n));
      if (hub.bus_e && bq.size() != 0) begin
        b = bq[0];
        chk("bus_fields", 64'({hub.bus_r, hub.bus_w, hub.bus_s, hub.bus_a, hub.bus_d}),
            64'({b.r, b.w, b.s, b.a, b.d}));
        if (hub.ena_bus) void'(bq.pop_front());
      end else if (!hub.bus_e) begin
        chk("bus_idle_zero", 64'({hub.bus_r, hub.bus_w, hub.bus_s, hub.bus_a, hub.bus_d}), 64'd0);
      end
      if (hub.done || hub.err) begin
        chk("done_err_excl", 64'(hub.done && hub.err), 64'd0);
        chk("busy_at_done", 64'(hub.busy), 64'd1);
        if (exq.size() == 0) begin
          chk("unexpected_done", 64'({hub.done, hub.err}), 64'd0);
        end else begin
          e = exq.pop_front();
          chk("kind", 64'({hub.done, hub.err}), e.err ? 64'd1 : 64'd2);
          chk("res_q", 64'(hub.res_q), 64'(e.q));
          chk("res_c", 64'(hub.res_c), 64'(e.c));
        end
      end
    end
  end

  initial begin
    int n;
    res           = 1'b1;
    hub.req       = 1'b1;
    hub.req_r     = 1'b1;
    hub.req_w     = 1'b0;
    hub.req_s     = 2'b10;
    hub.req_a     = 16'h0100;
    hub.req_d     = 32'h0;
    hub.ena_bus   = 1'b1;
    hub.bus_sel_n = 1'b1;
    hub.bus_ack_n = 1'b0;
    hub.bus_q     = 32'h0;
    hub.bus_c     = 1'b0;

    // Reset held with a request pending: nothing may leave IDLE.
    repeat (3) begin
      @(posedge clk_cog);
      @(negedge clk_cog);
      chk("rst_outputs", 64'({hub.busy, hub.done, hub.err, hub.res_c, hub.bus_e}), 64'd0);
      chk("rst_res_q", 64'(hub.res_q), 64'd0);
    end
    res           = 1'b0;
    hub.req       = 1'b0;
    hub.ena_bus   = 1'b0;
    hub.bus_sel_n = 1'b0;
    @(posedge clk_cog);
    @(negedge clk_cog);
    chk("idle_after_rst", 64'({hub.busy, hub.bus_e}), 64'd0);
    run = 1'b1;

    repeat (3000) begin
      tick();
      if (!hub.busy && $urandom_range(0, 1) == 1) begin
        issue(-1);
      end else if (hub.busy && $urandom_range(0, 3) == 0) begin
        hub.req   = 1'b1;
        hub.req_r = 1'($urandom);
        hub.req_w = 1'($urandom);
        hub.req_s = 2'($urandom);
        hub.req_a = 16'($urandom);
        hub.req_d = $urandom;
      end
    end
    drain();

    // Reset while waiting for the ack: back to IDLE with no completion.
    issue(0);
    n = 0;
    while (!(counting && seen >= 1) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_wait_ack", 64'(n < 200), 64'd1);
    res = 1'b1;
    void'(exq.pop_front());
    tick();
    res = 1'b0;
    mq  = 32'h0;
    mc  = 1'b0;
    chk("midrst_idle", 64'({hub.busy, hub.done, hub.err, hub.bus_e}), 64'd0);
    chk("midrst_res_q", 64'(hub.res_q), 64'd0);
    repeat (20) tick();
    issue(2);
    drain();
    chk("queues_empty", 64'(exq.size() + bq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
